// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and FIFO-buffered load responses onto one
// register-file write port (1-cycle registered latency) and tracks pending-load registers.
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_add_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_ready_o,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_rd_add_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_ready_o,
  input  logic        issue_load_i,
  input  logic [4:0]  issue_rd_i,
  output logic [31:0] busy_o,
  output logic        we_o,
  output logic [4:0]  rd_add_o,
  output logic [31:0] rd_data_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [4:0]    fifo_add_q [DEPTH];
  logic [31:0]   fifo_dat_q [DEPTH];
  logic [31:0]   busy_q, busy_d;
  logic          we_q, we_d;
  logic [4:0]    rd_add_q, rd_add_d;
  logic [31:0]   rd_data_q, rd_data_d;

  logic          full, empty, push, pop, sel_alu;
  logic [4:0]    head_add;
  logic [31:0]   head_dat;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);

  assign head_add = fifo_add_q[rptr_q[AW-1:0]];
  assign head_dat = fifo_dat_q[rptr_q[AW-1:0]];

  assign mem_ready_o = !full;
  assign alu_ready_o = !full;

  assign push    = mem_valid_i && !full;
  assign sel_alu = !full && alu_valid_i;
  assign pop     = full || (!alu_valid_i && !empty);

  always_comb begin
    wptr_d    = wptr_q + {{AW{1'b0}}, push};
    rptr_d    = rptr_q + {{AW{1'b0}}, pop};
    we_d      = 1'b0;
    rd_add_d  = 5'd0;
    rd_data_d = 32'd0;
    busy_d    = busy_q;
    if (sel_alu) begin
      we_d      = (alu_rd_add_i != 5'd0);
      rd_add_d  = alu_rd_add_i;
      rd_data_d = alu_data_i;
    end else if (pop) begin
      we_d      = (head_add != 5'd0);
      rd_add_d  = head_add;
      rd_data_d = head_dat;
      busy_d[head_add] = 1'b0;
    end
    // A new issue to the same register outranks the clear from a pop.
    if (issue_load_i && issue_rd_i != 5'd0) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      busy_q    <= '0;
      we_q      <= 1'b0;
      rd_add_q  <= 5'd0;
      rd_data_q <= 32'd0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
      rd_add_q  <= rd_add_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_add_q[wptr_q[AW-1:0]] <= mem_rd_add_i;
      fifo_dat_q[wptr_q[AW-1:0]] <= mem_data_i;
    end
  end

  assign busy_o    = busy_q;
  assign we_o      = we_q;
  assign rd_add_o  = rd_add_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_add_i;
  logic [31:0] alu_data_i;
  logic        alu_ready_o;
  logic        mem_valid_i;
  logic [4:0]  mem_rd_add_i;
  logic [31:0] mem_data_i;
  logic        mem_ready_o;
  logic        issue_load_i;
  logic [4:0]  issue_rd_i;
  logic [31:0] busy_o;
  logic        we_o;
  logic [4:0]  rd_add_o;
  logic [31:0] rd_data_o;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alu_valid_i(alu_valid_i), .alu_rd_add_i(alu_rd_add_i), .alu_data_i(alu_data_i),
    .alu_ready_o(alu_ready_o),
    .mem_valid_i(mem_valid_i), .mem_rd_add_i(mem_rd_add_i), .mem_data_i(mem_data_i),
    .mem_ready_o(mem_ready_o),
    .issue_load_i(issue_load_i), .issue_rd_i(issue_rd_i),
    .busy_o(busy_o), .we_o(we_o), .rd_add_o(rd_add_o), .rd_data_o(rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_busy = '0;
  logic        m_we = 1'b0;
  logic [4:0]  m_add = '0;
  logic [31:0] m_dat = '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check ready flags, advance the model, check registered outputs.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mr, input logic [31:0] md,
                      input logic il, input logic [4:0] ir);
    bit   full;
    ent_t e;
    alu_valid_i = av; alu_rd_add_i = ar; alu_data_i = ad;
    mem_valid_i = mv; mem_rd_add_i = mr; mem_data_i = md;
    issue_load_i = il; issue_rd_i = ir;
    #1;
    full = (m_q.size() == DEPTH);
    check("mem_ready", {31'd0, mem_ready_o}, {31'd0, !full});
    check("alu_ready", {31'd0, alu_ready_o}, {31'd0, !full});
    m_we = 1'b0;
    if (!full && av) begin
      m_we = (ar != 5'd0); m_add = ar; m_dat = ad;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_we = (e.a != 5'd0); m_add = e.a; m_dat = e.d;
      m_busy[e.a] = 1'b0;
    end
    if (il && ir != 5'd0) m_busy[ir] = 1'b1;
    if (mv && !full) m_q.push_back('{a: mr, d: md});
    @(posedge clk_i);
    #1;
    check("we", {31'd0, we_o}, {31'd0, m_we});
    check("busy", busy_o, m_busy);
    if (m_we) begin
      check("rd_add", {27'd0, rd_add_o}, {27'd0, m_add});
      check("rd_data", rd_data_o, m_dat);
    end
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    alu_valid_i = 1'b0; mem_valid_i = 1'b0; issue_load_i = 1'b0;
    #1;
    rst_i = 1'b1;
    #1;
    check("rst_busy", busy_o, 32'd0);
    check("rst_we", {31'd0, we_o}, 32'd0);
    check("rst_mem_ready", {31'd0, mem_ready_o}, 32'd1);
    check("rst_alu_ready", {31'd0, alu_ready_o}, 32'd1);
    m_q.delete(); m_busy = '0; m_we = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    alu_valid_i = 1'b0; alu_rd_add_i = '0; alu_data_i = '0;
    mem_valid_i = 1'b0; mem_rd_add_i = '0; mem_data_i = '0;
    issue_load_i = 1'b0; issue_rd_i = '0;
    #22;
    check("init_we", {31'd0, we_o}, 32'd0);
    check("init_busy", busy_o, 32'd0);
    check("init_rd_add", {27'd0, rd_add_o}, 32'd0);
    check("init_rd_data", rd_data_o, 32'd0);
    check("init_mem_ready", {31'd0, mem_ready_o}, 32'd1);
    check("init_alu_ready", {31'd0, alu_ready_o}, 32'd1);
    rst_i = 1'b0;

    // ALU write with empty FIFO
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("alu_we", {31'd0, we_o}, 32'd1);
    check("alu_rd", {27'd0, rd_add_o}, 32'd5);
    check("alu_data", rd_data_o, 32'hDEADBEEF);

    // Load to r7: busy until popped
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    idle();
    check("ld_busy7", busy_o, 32'h0000_0080);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
    check("ld_no_bypass", {31'd0, we_o}, 32'd0);
    idle();
    check("ld_we", {31'd0, we_o}, 32'd1);
    check("ld_rd", {27'd0, rd_add_o}, 32'd7);
    check("ld_data", rd_data_o, 32'h1234);
    check("ld_busy_clr", busy_o, 32'd0);

    // Fill the FIFO while ALU keeps it starved, then drain
    step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0);
    step(1'b1, 5'd1, 32'h12, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
    #1;
    check("full_mem_ready", {31'd0, mem_ready_o}, 32'd0);
    check("full_alu_ready", {31'd0, alu_ready_o}, 32'd0);
    step(1'b1, 5'd1, 32'h13, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
    check("drain_first", {27'd0, rd_add_o}, 32'd2);
    step(1'b1, 5'd1, 32'h14, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    step(1'b1, 5'd1, 32'h15, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    idle(); idle();

    // Register 0 is never written nor marked busy
    step(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    check("r0_we", {31'd0, we_o}, 32'd0);
    check("r0_busy", busy_o, 32'd0);

    // Set beats clear on the same bit
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h3, 1'b1, 5'd3);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    check("set_prio", busy_o, 32'h0000_0008);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h3, 1'b0, 5'd0);
    idle();

    // Reset mid-flight flushes a buffered entry
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    step(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'hAA, 1'b0, 5'd0);
    check("pre_rst_busy", busy_o, 32'h0000_0080);
    do_reset();
    idle();
    check("flush_we", {31'd0, we_o}, 32'd0);
    idle();

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 63) == 0) do_reset();
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
